board_mem_arbiter: RTL
======================

// Module: board_mem_arbiter
// PURPOSE
//  Owns the single board BRAM port; sits directly upstream of renderer (drives its data_in, consumes its addr_r_out/done_out).
//  Gives the port to renderer during active display and to the life-update engine during blanking (renderer done_out=1).
//  Update engine uses a req/gnt handshake; read data returns with a valid strobe after BRAM_LATENCY cycles.
// PARAMETERS
//  WORD_SIZE     codebase value  board word width (bits)
//  LOG_MAX_ADDR  codebase value  board address width
//  BRAM_LATENCY  2               cycles from mem_addr to mem_dout (1..4)
//  CNT_W         20              width of stats counter (ARB_STATS_EN only)
// PORTS
//  clk_130mhz        in   1             system clock; all logic on rising edge
//  rst_in            in   1             synchronous, active-high reset
//  done_in           in   1             renderer done_out; 1 = blanking, update window open
//  render_addr_in    in   LOG_MAX_ADDR  renderer addr_r_out
//  render_data_out   out  WORD_SIZE     to renderer data_in (= mem_dout)
//  upd_req_in        in   1             update engine requests one access
//  upd_we_in         in   1             1 = write, 0 = read (qualified by req&gnt)
//  upd_addr_in       in   LOG_MAX_ADDR  update access address
//  upd_wdata_in      in   WORD_SIZE     update write data
//  upd_gnt_out       out  1             access accepted this cycle
//  upd_rvalid_out    out  1             upd_rdata_out valid (one-cycle pulse per granted read)
//  upd_rdata_out     out  WORD_SIZE     read data
//  window_start_out  out  1             one-cycle pulse on entering UPDATE
//  mem_addr_out      out  LOG_MAX_ADDR  BRAM address
//  mem_we_out        out  1             BRAM write enable
//  mem_din_out       out  WORD_SIZE     BRAM write data
//  mem_dout_in       in   WORD_SIZE     BRAM read data
//  upd_cycles_out    out  CNT_W         granted accesses in last completed window
// BEHAVIOUR
//  - States: RENDER, UPDATE. Reset -> RENDER; every registered output 0; rvalid pipeline cleared.
//  - RENDER -> UPDATE on cycle after done_in seen 1 (registered done_q rise); window_start_out=1 that cycle.
//  - UPDATE -> RENDER when done_in=0; gating is combinational: upd_gnt_out = (state==UPDATE) & done_in & upd_req_in,
//    so no grant is issued in the cycle done_in falls.
//  - Mux (combinational): UPDATE&done_in -> mem_addr=upd_addr_in, mem_we=upd_gnt&upd_we_in, mem_din=upd_wdata_in;
//    otherwise mem_addr=render_addr_in, mem_we=0, mem_din=0. Renderer never writes.
//  - Handshake: access happens in a cycle with req&gnt. Requester holds addr/we/wdata while req&!gnt.
//    A req outside the window is stalled, never dropped or partially performed.
//  - Reads: a BRAM_LATENCY-deep shift register tracks (gnt & !we). upd_rvalid_out asserts exactly BRAM_LATENCY
//    cycles after the grant cycle, with upd_rdata_out=mem_dout_in. In-flight reads complete even if the window
//    closes meanwhile (pipeline independent of state).
//  - render_data_out = mem_dout_in always; valid for renderer BRAM_LATENCY cycles after RENDER mux restored.
//  - Back-to-back: one access per cycle at full rate; read-after-write same address returns written data.
//  - rst_in mid-window: grant drops same cycle; in-flight rvalids are discarded; state RENDER.
// CONFIGURATION
//  BOARD_ARB_STATS_EN defined: counter increments on each grant within a window (saturates at all-ones), clears on
//    window_start_out; on UPDATE->RENDER its value loads into upd_cycles_out (reset 0).
//  Not defined: no counter logic; upd_cycles_out tied to 0.
// TESTING
//  1 done_in=0, render_addr=0x10, BRAM holds 0xA5 -> render_data_out=0xA5 after 2 cycles; upd_req=1 never granted.
//  2 done_in 0->1 -> window_start pulse 1 cycle later, single cycle wide; next cycle req read addr 0x10 -> gnt=1,
//    rvalid=1 with rdata=0xA5 exactly 2 cycles after gnt.
//  3 In window: write 0x3C to addr 5 then read addr 5 next cycle -> rvalid returns 0x3C; mem_we high only in grant cycle.
//  4 Read granted in last window cycle, done_in falls next cycle -> rvalid still fires 2 cycles later; gnt=0 during fall cycle.
//  5 rst_in asserted during window with 2 reads in flight -> gnt=0 immediately, no rvalid pulses, window_start=0.
//  6 BOARD_ARB_STATS_EN: 37 granted accesses in one window -> upd_cycles_out=37 after window close; 0 when undefined.

Source files
------------

// File: rtl/board_mem_arbiter.sv
// Board BRAM port arbiter: renderer owns the port during active display, the life-update engine during blanking.
// Define BOARD_ARB_STATS_EN to count granted accesses per window onto upd_cycles_out (tied to 0 otherwise).
module board_mem_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int LOG_MAX_ADDR = 12,
    parameter int BRAM_LATENCY = 2,
    parameter int CNT_W        = 20
) (
    input  logic                    clk_130mhz,
    input  logic                    rst_in,
    input  logic                    done_in,
    input  logic [LOG_MAX_ADDR-1:0] render_addr_in,
    output logic [WORD_SIZE-1:0]    render_data_out,
    input  logic                    upd_req_in,
    input  logic                    upd_we_in,
    input  logic [LOG_MAX_ADDR-1:0] upd_addr_in,
    input  logic [WORD_SIZE-1:0]    upd_wdata_in,
    output logic                    upd_gnt_out,
    output logic                    upd_rvalid_out,
    output logic [WORD_SIZE-1:0]    upd_rdata_out,
    output logic                    window_start_out,
    output logic [LOG_MAX_ADDR-1:0] mem_addr_out,
    output logic                    mem_we_out,
    output logic [WORD_SIZE-1:0]    mem_din_out,
    input  logic [WORD_SIZE-1:0]    mem_dout_in,
    output logic [CNT_W-1:0]        upd_cycles_out
);
    typedef enum logic {RENDER = 1'b0, UPDATE = 1'b1} state_t;

    state_t                  state_q;
    logic                    window_start_q;
    logic [BRAM_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
    logic                    win_open, gnt, enter_upd, leave_upd;

    // The window closes combinationally with done_in so nothing is granted in the falling cycle.
    assign win_open  = (state_q == UPDATE) && done_in && !rst_in;
    assign gnt       = win_open && upd_req_in;
    assign enter_upd = (state_q == RENDER) && done_in;
    assign leave_upd = (state_q == UPDATE) && !done_in;

    assign upd_gnt_out      = gnt;
    assign window_start_out = window_start_q;
    assign mem_addr_out     = win_open ? upd_addr_in  : render_addr_in;
    assign mem_we_out       = gnt && upd_we_in;
    assign mem_din_out      = win_open ? upd_wdata_in : '0;
    assign render_data_out  = mem_dout_in;
    assign upd_rdata_out    = mem_dout_in;
    assign upd_rvalid_out   = rd_pipe_q[BRAM_LATENCY-1] && !rst_in;

    // Read tracker runs regardless of state so reads finish after the window closes.
    always_comb begin
        rd_pipe_d    = '0;
        rd_pipe_d[0] = gnt && !upd_we_in;
        for (int i = 1; i < BRAM_LATENCY; i++) rd_pipe_d[i] = rd_pipe_q[i-1];
    end

    always_ff @(posedge clk_130mhz) begin
        if (rst_in) begin
            state_q        <= RENDER;
            window_start_q <= 1'b0;
            rd_pipe_q      <= '0;
        end else begin
            rd_pipe_q      <= rd_pipe_d;
            window_start_q <= enter_upd;
            case (state_q)
                RENDER:  if (done_in)  state_q <= UPDATE;
                UPDATE:  if (!done_in) state_q <= RENDER;
                default: state_q <= RENDER;
            endcase
        end
    end

`ifdef BOARD_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q, cycles_q;

    always_ff @(posedge clk_130mhz) begin
        if (rst_in) begin
            cnt_q    <= '0;
            cycles_q <= '0;
        end else begin
            if (enter_upd)
                cnt_q <= '0;
            else if (gnt && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + CNT_W'(1);
            if (leave_upd)
                cycles_q <= cnt_q;
        end
    end

    assign upd_cycles_out = cycles_q;
`else
    assign upd_cycles_out = '0;
`endif

endmodule
